// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with prescaler, run/pause FSM,
// terminal-count pulse and active-low seven-segment outputs.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic [6:0] hex0,
    output logic [6:0] hex1
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            done_q, done_d;

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= 8'h00;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        if (load) begin
            cnt_d   = {sat_digit(load_val[7:4]), sat_digit(load_val[3:0])};
            pre_d   = '0;
            state_d = IDLE;
        end else if (pause) begin
            // Pause swallows any same-cycle step; prescaler stays frozen.
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else if (start && state_q == IDLE) begin
            if (cnt_q != 8'h00) begin
                state_d = RUN;
                pre_d   = '0;
            end
        end else if (start && state_q == PAUSED) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                cnt_d = bcd_dec(cnt_q);
                if (cnt_q == 8'h01) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    assign count = cnt_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSED);
    assign done  = done_q;
    assign hex0  = seg7(cnt_q[3:0]);
    assign hex1  = seg7(cnt_q[7:4]);

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Two-digit BCD countdown timer (00–99) with a prescaler, a run/pause control FSM, a terminal-count pulse and active-low seven-segment outputs. It is the down-counting counterpart to the lab's enable/clear up-counters. It sits between the board switches/pushbuttons and the HEX displays, and `done` can drive an LED or an interrupt line.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per count step (1 s at 50 MHz); legal range ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `clear` input 1: asynchronous, active-high reset. Clock is `clk`; reset is asynchronous and active-high.
- `load` input 1: single-cycle strobe; loads `load_val` into the counter.
- `load_val` input 8: BCD preset; [7:4] tens, [3:0] ones.
- `start` input 1: single-cycle strobe; begins or resumes counting.
- `pause` input 1: single-cycle strobe; suspends counting.
- `count` output 8: current BCD value; [7:4] tens, [3:0] ones.
- `busy` output 1: high in RUN and PAUSED.
- `done` output 1: one-cycle pulse when the count reaches 00 while running.
- `hex0` output 7: active-low segments for the ones digit; bit0 = a … bit6 = g.
- `hex1` output 7: active-low segments for the tens digit; same encoding.

## Operation
- **States:** IDLE, RUN, PAUSED, DONE. Reset state is IDLE.
- **Input priority each cycle:** `clear` > `load` > `pause` > `start`. Lower-priority strobes in the same cycle are ignored.
- **load (any state):**
  - `count` ← `load_val`. Any digit > 9 saturates to 9, so 8'hA5 loads 95 and 8'hFF loads 99.
  - Prescaler ← 0; state ← IDLE.
- **start:**
  - IDLE with `count` ≠ 00 → RUN, prescaler ← 0.
  - IDLE with `count` = 00 → ignored.
  - PAUSED → RUN with the prescaler value retained.
  - RUN or DONE → ignored.
- **pause:** RUN → PAUSED with prescaler and `count` frozen. Ignored in every other state.
- **RUN stepping:**
  - The prescaler increments every cycle.
  - When prescaler = TICK_DIV−1, it wraps to 0 and `count` decrements by one in BCD: ones 0 → 9 with a tens borrow, otherwise ones−1.
- **Terminal count:** the decrement from 01 to 00 moves the state to DONE and asserts `done` for exactly one cycle.
- **DONE:** `count` holds 00, `busy` = 0. Only `load` (or `clear`) leaves DONE; `start` is ignored.
- **Seven-segment decode:** combinational from `count`, active-low.
  - Digits 0–9: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Digit codes > 9 cannot occur, because loads saturate.
- **Prescaler width:** `$clog2(TICK_DIV)` bits.

## Timing
- **Reset values** (while `clear` = 1, asynchronously): `count` = 8'h00, `busy` = 0, `done` = 0, `hex0` = `hex1` = 7'h40, state IDLE, prescaler 0.
- **load latency:** `load` sampled at edge k → `count` = `load_val` after edge k.
- **First step:** with `start` sampled at edge k from IDLE, `busy` = 1 after edge k and the first decrement lands at edge k+TICK_DIV. Later decrements come every TICK_DIV cycles.
- **Resume:** pausing at prescaler value p and resuming at edge m puts the next decrement at edge m+(TICK_DIV−p).
- **done:** registered, high in the cycle immediately after the edge where `count` becomes 00. `busy` falls at the same edge.
- **Segment outputs:** combinational, so `hex0`/`hex1` change in the same cycle as `count`.
- **Mid-operation reset:** `clear` asserted during RUN immediately forces all reset values; no `done` pulse is produced.
- **Edge collisions:**
  - `load` in the same cycle as a decrement edge: `load` wins, no decrement occurs, and `done` stays 0.
  - `pause` on the same cycle as a decrement edge: `pause` wins, the step is not taken, and the prescaler holds TICK_DIV−1. A later `start` then decrements one cycle after the resume edge.

## Test plan
Run all scenarios with TICK_DIV=4.
- **Reset:** assert `clear` mid-run → `count`=00, `busy`=0, `done`=0, `hex0`=`hex1`=7'h40 without waiting for a clock edge.
- **Full countdown:** load 8'h03, then `start` → `count` goes 03 → 02 → 01 → 00 at 4, 8, 12 cycles after `start`. `done` is high for exactly one cycle after reaching 00; `busy` is then 0.
- **BCD borrow and display:** load 8'h10, start → after 4 cycles `count`=09, `hex1`=7'h40, `hex0`=7'h10. Load 8'hA5 → `count`=95.
- **Pause/resume:** load 8'h05, start, pause 2 cycles in, wait 20 cycles → `count` stays 05. Start again → the decrement to 04 occurs exactly 2 cycles after the resume edge.
- **Ignored strobes:**
  - Start with `count`=00 → stays IDLE, `busy`=0.
  - Start in DONE → no change.
  - `pause` and `start` in the same cycle during RUN → PAUSED.
- **Load collision:** during RUN at 01, assert `load` (8'h42) on the decrement edge → `count`=42, state IDLE, no `done` pulse.
